secuenciador_instr: RTL and testbench

SECUENCIADOR_INSTR -- requirements
Module: secuenciador_instr

---
 rtl/chocorrol_pkg.sv | 46 ++++
 rtl/fifo_instr.sv | 69 ++++++
 rtl/secuenciador_instr.sv | 158 +++++++++++++++
 tb/tb_secuenciador_instr.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/chocorrol_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : chocorrol_pkg
//  Description : Instruction word field layout, MC codes and the issue
//                FSM state type shared by the instruction sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
package chocorrol_pkg;

    // Instruction word: MC[19:18] OP1[17:13] ALUC[12:10] OP2[9:5] MB[4:0]
    localparam int c_instr_w   = 20;
    localparam int c_mc_msb    = 19;
    localparam int c_mc_lsb    = 18;
    localparam int c_op1_msb   = 17;
    localparam int c_op1_lsb   = 13;
    localparam int c_aluc_msb  = 12;
    localparam int c_aluc_lsb  = 10;
    localparam int c_op2_msb   = 9;
    localparam int c_op2_lsb   = 5;
    localparam int c_mb_msb    = 4;
    localparam int c_mb_lsb    = 0;

    localparam int c_dato_w    = 32;
    localparam int c_cont_w    = 16;

    // Memory-control codes carried in MC
    localparam logic [1:0] c_mc_nop       = 2'b00;
    localparam logic [1:0] c_mc_escribe_a = 2'b01;
    localparam logic [1:0] c_mc_escribe_b = 2'b10;
    localparam logic [1:0] c_mc_reservado = 2'b11;

    // Issue FSM states
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        EMITE   = 2'd1,
        CAPTURA = 2'd2,
        ENTREGA = 2'd3
    } estado_t;

    // Extract the MC field of an instruction word
    function automatic logic [1:0] get_mc(input logic [c_instr_w-1:0] w);
        return w[c_mc_msb:c_mc_lsb];
    endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_instr.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_instr
//  Description : Synchronous instruction FIFO, power-of-two depth, head word
//                visible combinationally. Pushes while full are ignored.
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo_instr #(
    parameter int PROF  = 8,
    parameter int ANCHO = 20
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [ANCHO-1:0] i_dato,
    input  logic             i_pop,
    output logic [ANCHO-1:0] o_dato,
    output logic             o_full,
    output logic             o_empty
);

    localparam int c_ptr_w = $clog2(PROF);
    localparam logic [c_ptr_w:0] c_lleno = (c_ptr_w + 1)'(PROF);

    logic [ANCHO-1:0]   r_mem [PROF];
    logic [c_ptr_w-1:0] r_wr;
    logic [c_ptr_w-1:0] r_rd;
    logic [c_ptr_w:0]   r_count;

    logic w_push;
    logic w_pop;

    // A full FIFO never accepts a word, even when it is being popped
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_full  = (r_count == c_lleno);
    assign o_empty = (r_count == '0);
    assign o_dato  = r_mem[r_rd];

    // Storage array, written only on an accepted push
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr] <= i_dato;
        end
    end

    // Pointers wrap naturally modulo PROF; occupancy tracked separately
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wr <= r_wr + 1'b1;
            end
            if (w_pop) begin
                r_rd <= r_rd + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/secuenciador_instr.sv
`default_nettype none
// ============================================================================
//  Module      : secuenciador_instr
//  Description : Buffers host instruction words, issues them one at a time
//                to the datapath core, discards reserved words, and captures
//                the core read data of memory-B stores for the host.
//  Revision    : 1.0 - initial release
// ============================================================================
module secuenciador_instr
    import chocorrol_pkg::*;
#(
    parameter int PROF = 8
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 IN_VALID,
    input  logic [c_instr_w-1:0] IN_INSTR,
    output logic                 IN_READY,
    output logic [c_instr_w-1:0] INSTRUCCION,
    output logic                 EMITIDA,
    input  logic [c_dato_w-1:0]  RESULTADO,
    output logic                 OUT_VALID,
    output logic [c_dato_w-1:0]  OUT_DATO,
    input  logic                 OUT_READY,
    output logic                 ERR_MC,
    output logic [c_cont_w-1:0]  CONTADOR
);

    estado_t              r_estado;
    estado_t              w_estado_sig;

    logic [c_instr_w-1:0] r_instr;
    logic                 r_emitida;
    logic                 r_err;
    logic                 r_out_valid;
    logic [c_dato_w-1:0]  r_out_dato;
    logic [c_cont_w-1:0]  r_contador;

    logic [c_instr_w-1:0] w_cabeza;
    logic                 w_full;
    logic                 w_empty;
    logic                 w_pop;
    logic                 w_emite;
    logic                 w_err;

    fifo_instr #(
        .PROF  (PROF),
        .ANCHO (c_instr_w)
    ) u_fifo (
        .clk     (CLK),
        .rst     (RST),
        .i_push  (IN_VALID),
        .i_dato  (IN_INSTR),
        .i_pop   (w_pop),
        .o_dato  (w_cabeza),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign IN_READY    = !w_full;
    assign INSTRUCCION = r_instr;
    assign EMITIDA     = r_emitida;
    assign OUT_VALID   = r_out_valid;
    assign OUT_DATO    = r_out_dato;
    assign ERR_MC      = r_err;
    assign CONTADOR    = r_contador;

    // FSM state register
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_estado <= IDLE;
        end else begin
            r_estado <= w_estado_sig;
        end
    end

    // Next state, FIFO pop and issue/discard decisions
    always_comb begin
        w_estado_sig = r_estado;
        w_pop        = 1'b0;
        w_emite      = 1'b0;
        w_err        = 1'b0;
        case (r_estado)
            IDLE: begin
                if (!w_empty) begin
                    w_pop = 1'b1;
                    if (get_mc(w_cabeza) == c_mc_reservado) begin
                        w_err = 1'b1;
                    end else begin
                        w_emite      = 1'b1;
                        w_estado_sig = EMITE;
                    end
                end
            end
            EMITE: begin
                // Only memory-B stores return data worth capturing
                if (get_mc(r_instr) == c_mc_escribe_b) begin
                    w_estado_sig = CAPTURA;
                end else begin
                    w_estado_sig = IDLE;
                end
            end
            CAPTURA: begin
                w_estado_sig = ENTREGA;
            end
            ENTREGA: begin
                if (OUT_READY) begin
                    w_estado_sig = IDLE;
                end
            end
            default: begin
                w_estado_sig = IDLE;
            end
        endcase
    end

    // Issue register: the core only ever sees a real word for a single cycle
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_instr   <= '0;
            r_emitida <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_err <= w_err;
            if (w_emite) begin
                r_instr   <= w_cabeza;
                r_emitida <= 1'b1;
            end else begin
                r_instr   <= '0;
                r_emitida <= 1'b0;
            end
        end
    end

    // Issue counter, wraps naturally at its width
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_contador <= '0;
        end else if (r_estado == EMITE) begin
            r_contador <= r_contador + 1'b1;
        end
    end

    // Capture core read data one cycle after issue and hold it for the host
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_out_valid <= 1'b0;
            r_out_dato  <= '0;
        end else if (r_estado == CAPTURA) begin
            r_out_valid <= 1'b1;
            r_out_dato  <= RESULTADO;
        end else if ((r_estado == ENTREGA) && OUT_READY) begin
            r_out_valid <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_secuenciador_instr.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_secuenciador_instr
//  Description : Scoreboard bench for the instruction sequencer. Accepted
//                words are queued in pop order; a negedge monitor matches
//                issues, reserved-word pulses, counter and captured data.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_secuenciador_instr;

    localparam int PROF = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [19:0] in_instr;
    logic        in_ready;
    logic [19:0] instruccion;
    logic        emitida;
    logic [31:0] resultado = '0;
    logic        out_valid;
    logic [31:0] out_dato;
    logic        out_ready;
    logic        err_mc;
    logic [15:0] contador;

    secuenciador_instr #(.PROF(PROF)) dut (
        .CLK         (clk),
        .RST         (rst),
        .IN_VALID    (in_valid),
        .IN_INSTR    (in_instr),
        .IN_READY    (in_ready),
        .INSTRUCCION (instruccion),
        .EMITIDA     (emitida),
        .RESULTADO   (resultado),
        .OUT_VALID   (out_valid),
        .OUT_DATO    (out_dato),
        .OUT_READY   (out_ready),
        .ERR_MC      (err_mc),
        .CONTADOR    (contador)
    );

    always #5 clk = ~clk;

    // ---------------- reference model state ----------------
    logic [19:0] exp_q[$];     // accepted words, in the order they leave the FIFO
    logic [31:0] out_q[$];     // expected captured data, one per MC=10 word
    logic [15:0] exp_cnt = '0;
    int          n_checks = 0;
    int          n_pass   = 0;
    int          err_seen = 0;
    int          cyc      = 0;
    int          emit_cyc = 0;
    logic        use_fijo = 1'b0;
    logic [31:0] dato_fijo = '0;

    function automatic logic [31:0] core_f(input logic [19:0] w);
        return {w[11:0], w} ^ 32'hC3A5_0000;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Core model: memory-B read data appears one cycle after the issue cycle
    always @(posedge clk) begin
        if (emitida) resultado <= use_fijo ? dato_fijo : core_f(instruccion);
        else         resultado <= $urandom;
    end

    // ---------------- monitor ----------------
    logic        prev_emit = 1'b0;
    logic        prev_ov   = 1'b0;
    logic        prev_ordy = 1'b0;
    logic [31:0] prev_dato = '0;
    logic [19:0] mon_w;

    always @(negedge clk) begin
        if (rst) begin
            prev_emit = 1'b0;
            prev_ov   = 1'b0;
            prev_ordy = 1'b0;
        end else begin
            cyc++;
            if (prev_emit) check("contador", {16'h0, contador}, {16'h0, exp_cnt});
            if (emitida) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL issue_unexpected: got %h expected no issue", instruccion);
                end else begin
                    mon_w = exp_q.pop_front();
                    check("issue_not_reserved", {31'h0, emitida}, {31'h0, (mon_w[19:18] != 2'b11)});
                    check("issue_word", {12'h0, instruccion}, {12'h0, mon_w});
                end
                exp_cnt  = exp_cnt + 16'd1;
                emit_cyc = cyc;
            end else begin
                check("instr_zero", {12'h0, instruccion}, 32'h0);
            end
            if (err_mc) begin
                err_seen++;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL err_unexpected: got %b expected 0", err_mc);
                end else begin
                    mon_w = exp_q.pop_front();
                    check("err_mc_reserved", {31'h0, err_mc}, {31'h0, (mon_w[19:18] == 2'b11)});
                end
            end
            if (out_valid && !prev_ov) begin
                check("out_latency", 32'(cyc - emit_cyc), 32'd2);
                if (out_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL out_unexpected: got %h expected no capture", out_dato);
                end else begin
                    check("out_dato", out_dato, out_q.pop_front());
                end
            end
            if (prev_ov && !prev_ordy) begin
                check("out_hold_valid", {31'h0, out_valid}, 32'h1);
                check("out_hold_dato", out_dato, prev_dato);
            end
            if (prev_ov && prev_ordy) check("out_clear", {31'h0, out_valid}, 32'h0);
            prev_emit = emitida;
            prev_ov   = out_valid;
            prev_ordy = out_ready;
            prev_dato = out_dato;
        end
    end

    // ---------------- stimulus helpers (entered and left at posedge+1) ----------------
    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic model_push(input logic [19:0] w);
        exp_q.push_back(w);
        if (w[19:18] == 2'b10) out_q.push_back(use_fijo ? dato_fijo : core_f(w));
    endtask

    task automatic drive(input logic v, input logic [19:0] w);
        in_valid = v;
        in_instr = w;
        @(negedge clk);
        if (v && in_ready && !rst) model_push(w);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        in_valid = 1'b0;
        exp_q.delete();
        out_q.delete();
        exp_cnt  = '0;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int k = 0;
        while ((exp_q.size() != 0 || out_q.size() != 0 || out_valid) && k < budget) begin
            idle(1);
            k++;
        end
        check("drain_in_time", {31'h0, (k < budget)}, 32'h1);
        idle(3);
    endtask

    // Hard stop in case something wedges the bench itself
    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int k;
        int err0;
        rst = 1'b1; in_valid = 1'b0; in_instr = '0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        // Reset values
        check("rst_instruccion", {12'h0, instruccion}, 32'h0);
        check("rst_emitida", {31'h0, emitida}, 32'h0);
        check("rst_out_valid", {31'h0, out_valid}, 32'h0);
        check("rst_out_dato", out_dato, 32'h0);
        check("rst_err_mc", {31'h0, err_mc}, 32'h0);
        check("rst_contador", {16'h0, contador}, 32'h0);
        check("rst_in_ready", {31'h0, in_ready}, 32'h1);
        rst = 1'b0;

        // Single issue of an A-write
        drive(1'b1, 20'h46880);
        idle(5);
        check("s1_contador", {16'h0, contador}, 32'd1);
        check("s1_out_valid", {31'h0, out_valid}, 32'h0);

        // Store capture, held while the host stalls
        use_fijo = 1'b1; dato_fijo = 32'hDEADBEEF; out_ready = 1'b0;
        drive(1'b1, 20'h86887);
        k = 0;
        while (!out_valid && k < 10) begin idle(1); k++; end
        check("s2_valid_seen", {31'h0, out_valid}, 32'h1);
        check("s2_dato", out_dato, 32'hDEADBEEF);
        idle(5);
        check("s2_still_valid", {31'h0, out_valid}, 32'h1);
        out_ready = 1'b1;
        idle(1);
        check("s2_cleared", {31'h0, out_valid}, 32'h0);
        use_fijo = 1'b0;
        idle(2);

        // FIFO fills while the FSM is stalled in ENTREGA
        out_ready = 1'b0;
        drive(1'b1, 20'h8A001);
        k = 0;
        while (!out_valid && k < 10) begin idle(1); k++; end
        check("s3_stalled", {31'h0, out_valid}, 32'h1);
        for (int i = 0; i < PROF; i++) drive(1'b1, {2'b01, 18'($urandom)});
        check("s3_full", {31'h0, in_ready}, 32'h0);
        drive(1'b1, 20'h4FFFF);
        out_ready = 1'b1;
        wait_drain(200);

        // Reserved opcode is discarded
        do_reset();
        err0 = err_seen;
        drive(1'b1, 20'hC0000);
        drive(1'b1, 20'h46880);
        idle(6);
        check("s4_err_pulses", 32'(err_seen - err0), 32'd1);
        check("s4_contador", {16'h0, contador}, 32'd1);

        // Counter wrap
        force dut.r_contador = 16'hFFFF;
        exp_cnt = 16'hFFFF;
        @(negedge clk);
        check("s5_preload", {16'h0, contador}, 32'h0000FFFF);
        release dut.r_contador;
        @(posedge clk); #1;
        drive(1'b1, 20'h00000);
        idle(4);
        check("s5_wrap", {16'h0, contador}, 32'h0);

        // Reset while capturing a store
        do_reset();
        out_ready = 1'b0;
        drive(1'b1, 20'h8B0C3);
        k = 0;
        while (!emitida && k < 5) begin idle(1); k++; end
        check("s6_issued", {31'h0, emitida}, 32'h1);
        drive(1'b1, 20'h41234);   // lands in the FIFO; FSM now in CAPTURA
        do_reset();
        check("s6_out_valid", {31'h0, out_valid}, 32'h0);
        check("s6_instruccion", {12'h0, instruccion}, 32'h0);
        check("s6_contador", {16'h0, contador}, 32'h0);
        check("s6_in_ready", {31'h0, in_ready}, 32'h1);
        out_ready = 1'b1;
        idle(6);
        check("s6_fifo_flushed", {16'h0, contador}, 32'h0);

        // Randomized traffic with random host back-pressure
        for (int i = 0; i < 400; i++) begin
            logic [31:0] r;
            r = $urandom;
            out_ready = ($urandom_range(0, 3) != 0);
            drive(1'(($urandom_range(0, 2) != 0)), r[19:0]);
        end
        out_ready = 1'b1;
        wait_drain(600);
        check("sb_words_left", 32'(exp_q.size()), 32'h0);
        check("sb_data_left", 32'(out_q.size()), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
